fdd_track_loader: RTL and testbench

Floppy track-buffer controller between the HPS SD block interface (`sd_lba[0]`, `sd_rd[0]`, `sd_wr[0]`, `sd_ack[0]`) and the disk track RAM in `apple2_top`. When the drive head moves to a new track, or a new image is mounted, the block fetches that track as SECS_PER_TRACK consecutive 512-byte blocks. If the resident track was modified and the image is writable, it first writes that track back. It holds the CPU (`cpu_wait`) for the whole transfer and supplies `track_sec`, the upper bits of the track-RAM address.

---
 rtl/fdd_track_loader.sv | 180 ++++++++++++++++++
 tb/tb_fdd_track_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fdd_track_loader.sv
// Floppy track-buffer controller: writes back a dirty resident track and loads the
// track under the head as SECS_PER_TRACK consecutive 512-byte SD blocks.
module fdd_track_loader #(
  parameter int unsigned SECS_PER_TRACK = 13,
  parameter int unsigned TRACK_W        = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic               dirty_set,
  input  logic               sd_ack,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               busy
);

  localparam int unsigned LBA_W = 32;
  localparam int unsigned SEC_W = 4;
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [TRACK_W-1:0] cur_track, cur_track_n;
  logic               loaded, loaded_n;
  logic               dirty, dirty_n;
  logic               ro, ro_n;
  logic               old_ack;
  // rearm: issue the next block request one cycle after an ack fall
  logic               rearm, rearm_n;
  // acked: the outstanding request has seen its ack rise, so its fall is ours
  logic               acked, acked_n;
  logic [LBA_W-1:0]   sd_lba_n;
  logic               sd_rd_n, sd_wr_n;
  logic [SEC_W-1:0]   track_sec_n;
  logic               cpu_wait_n, busy_n;

  logic             ack_rise_c, ack_fall_c, trigger_c;
  logic [LBA_W-1:0] base_cur_c, base_trk_c;

  assign ack_rise_c = sd_ack & ~old_ack;
  assign ack_fall_c = ~sd_ack & old_ack;
  assign trigger_c  = img_present & (~loaded | (track != cur_track));
  assign base_cur_c = LBA_W'(SECS_PER_TRACK) * LBA_W'(cur_track);
  assign base_trk_c = LBA_W'(SECS_PER_TRACK) * LBA_W'(track);

  // State and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cur_track <= '0;
      loaded    <= 1'b0;
      dirty     <= 1'b0;
      ro        <= 1'b0;
      old_ack   <= 1'b0;
      rearm     <= 1'b0;
      acked     <= 1'b0;
      sd_lba    <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      track_sec <= '0;
      cpu_wait  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cur_track <= cur_track_n;
      loaded    <= loaded_n;
      dirty     <= dirty_n;
      ro        <= ro_n;
      old_ack   <= sd_ack;
      rearm     <= rearm_n;
      acked     <= acked_n;
      sd_lba    <= sd_lba_n;
      sd_rd     <= sd_rd_n;
      sd_wr     <= sd_wr_n;
      track_sec <= track_sec_n;
      cpu_wait  <= cpu_wait_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n     = state;
    cur_track_n = cur_track;
    loaded_n    = loaded;
    dirty_n     = dirty;
    ro_n        = ro;
    rearm_n     = rearm;
    acked_n     = acked;
    sd_lba_n    = sd_lba;
    sd_rd_n     = sd_rd;
    sd_wr_n     = sd_wr;
    track_sec_n = track_sec;

    unique case (state)
      ST_IDLE: begin
        if (trigger_c) begin
          track_sec_n = '0;
          rearm_n     = 1'b0;
          acked_n     = 1'b0;
          if (dirty && loaded && !ro) begin
            state_n  = ST_FLUSH;
            sd_wr_n  = 1'b1;
            sd_lba_n = base_cur_c;
          end else begin
            state_n     = ST_LOAD;
            cur_track_n = track;
            dirty_n     = 1'b0;
            sd_rd_n     = 1'b1;
            sd_lba_n    = base_trk_c;
          end
        end
      end
      ST_FLUSH, ST_LOAD: begin
        if (rearm) begin
          rearm_n  = 1'b0;
          sd_lba_n = base_cur_c + LBA_W'(track_sec);
          if (state == ST_FLUSH) sd_wr_n = 1'b1;
          else                   sd_rd_n = 1'b1;
        end
        if (ack_rise_c && (sd_rd || sd_wr)) begin
          sd_rd_n = 1'b0;
          sd_wr_n = 1'b0;
          acked_n = 1'b1;
        end
        if (ack_fall_c && acked) begin
          acked_n = 1'b0;
          if (track_sec == LAST_SEC) begin
            track_sec_n = '0;
            if (state == ST_FLUSH) begin
              cur_track_n = track;
              dirty_n     = 1'b0;
              state_n     = ST_LOAD;
              rearm_n     = 1'b1;
            end else begin
              loaded_n = 1'b1;
              state_n  = ST_IDLE;
            end
          end else begin
            track_sec_n = track_sec + SEC_W'(1);
            rearm_n     = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (dirty_set) dirty_n = 1'b1;

    // A mount overrides everything else in the same cycle, including an abort.
    if (img_mounted) begin
      loaded_n    = 1'b0;
      dirty_n     = 1'b0;
      ro_n        = img_readonly;
      state_n     = ST_IDLE;
      cur_track_n = cur_track;
      sd_lba_n    = sd_lba;
      sd_rd_n     = 1'b0;
      sd_wr_n     = 1'b0;
      rearm_n     = 1'b0;
      acked_n     = 1'b0;
      track_sec_n = '0;
    end

    busy_n     = (state_n != ST_IDLE);
    cpu_wait_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_fdd_track_loader.sv
// Directed bench for fdd_track_loader: an SD acknowledge model walks each track
// transfer and checks request kind, LBA, block index and CPU stall cycle by cycle.
module tb_fdd_track_loader;

  localparam int SPT = 13;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [5:0]  track;
  logic        img_mounted, img_present, img_readonly, dirty_set, sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, cpu_wait, busy;
  logic [3:0]  track_sec;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  fdd_track_loader #(.SECS_PER_TRACK(13), .TRACK_W(6)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
    .img_mounted(img_mounted), .img_present(img_present),
    .img_readonly(img_readonly), .dirty_set(dirty_set), .sd_ack(sd_ack),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .track_sec(track_sec),
    .cpu_wait(cpu_wait), .busy(busy)
  );

  // Serve n blocks of one pass starting at LBA base; busy_after is the expected
  // busy/cpu_wait level on the cycle after the final ack fall.
  task automatic serve_track(input logic is_wr, input int base, input int n,
                             input logic busy_after);
    int wait_cnt;
    logic [3:0] exp_sec;
    wait_cnt = 0;
    while (!(sd_rd || sd_wr) && wait_cnt < 60) begin
      @(negedge clk_sys);
      wait_cnt++;
    end
    if (!(sd_rd || sd_wr)) begin
      checks++; errors++;
      $display("FAIL req_timeout base=%0d: no request after %0d cycles", base, wait_cnt);
      return;
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (sd_wr !== is_wr || sd_rd !== !is_wr) begin
        errors++;
        $display("FAIL req_kind blk=%0d: rd=%b wr=%b, required wr=%b", i, sd_rd, sd_wr, is_wr);
      end
      checks++;
      if (sd_lba !== 32'(base + i)) begin
        errors++;
        $display("FAIL lba blk=%0d: got %0d, required %0d", i, sd_lba, base + i);
      end
      checks++;
      if (track_sec !== 4'(i)) begin
        errors++;
        $display("FAIL track_sec blk=%0d: got %0d, required %0d", i, track_sec, i);
      end
      checks++;
      if (cpu_wait !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall blk=%0d: cpu_wait=%b busy=%b, required 1 1", i, cpu_wait, busy);
      end
      sd_ack = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        errors++;
        $display("FAIL req_drop blk=%0d: rd=%b wr=%b, required 0 0", i, sd_rd, sd_wr);
      end
      @(negedge clk_sys);
      @(negedge clk_sys);
      checks++;
      if (sd_lba !== 32'(base + i)) begin
        errors++;
        $display("FAIL lba_hold blk=%0d: got %0d, required %0d", i, sd_lba, base + i);
      end
      sd_ack = 1'b0;
      @(negedge clk_sys);
      exp_sec = (i == SPT - 1) ? 4'd0 : 4'(i + 1);
      checks++;
      if (track_sec !== exp_sec || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        errors++;
        $display("FAIL after_fall blk=%0d: track_sec=%0d rd=%b wr=%b, required %0d 0 0",
                 i, track_sec, sd_rd, sd_wr, exp_sec);
      end
      if (i == SPT - 1) begin
        checks++;
        if (busy !== busy_after || cpu_wait !== busy_after) begin
          errors++;
          $display("FAIL end_stall: busy=%b cpu_wait=%b, required %b", busy, cpu_wait, busy_after);
        end
      end else begin
        @(negedge clk_sys);
        checks++;
        if (!(sd_rd || sd_wr)) begin
          errors++;
          $display("FAIL req_rearm blk=%0d: rd=%b wr=%b, required a request", i, sd_rd, sd_wr);
        end
      end
    end
  endtask

  task automatic pulse_mount(input logic readonly);
    img_readonly = readonly;
    img_mounted  = 1'b1;
    @(negedge clk_sys);
    img_mounted  = 1'b0;
  endtask

  task automatic pulse_dirty();
    dirty_set = 1'b1;
    @(negedge clk_sys);
    dirty_set = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; track = 6'd0; img_mounted = 1'b0; img_present = 1'b0;
    img_readonly = 1'b0; dirty_set = 1'b0; sd_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({sd_rd, sd_wr, cpu_wait, busy} !== 4'b0 || track_sec !== 4'd0 || sd_lba !== 32'd0) begin
      errors++;
      $display("FAIL reset_vals: rd=%b wr=%b wait=%b busy=%b sec=%0d lba=%0d, required all 0",
               sd_rd, sd_wr, cpu_wait, busy, track_sec, sd_lba);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_image: busy=%b rd=%b, required 0 0", busy, sd_rd);
    end
  endtask

  task automatic test_mount_load();
    img_present = 1'b1;
    pulse_mount(1'b0);
    serve_track(1'b0, 0, SPT, 1'b0);
  endtask

  task automatic test_stray_ack();
    sd_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    sd_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0 || track_sec !== 4'd0) begin
      errors++;
      $display("FAIL stray_ack: busy=%b rd=%b wr=%b sec=%0d, required 0 0 0 0",
               busy, sd_rd, sd_wr, track_sec);
    end
  endtask

  task automatic test_clean_seek();
    track = 6'd5;
    serve_track(1'b0, 65, SPT, 1'b0);
  endtask

  task automatic test_back_to_back();
    pulse_dirty();
    track = 6'd6;
    serve_track(1'b1, 65, SPT, 1'b1);
    serve_track(1'b0, 78, SPT, 1'b0);
  endtask

  task automatic test_readonly();
    track = 6'd5;
    pulse_mount(1'b1);
    serve_track(1'b0, 65, SPT, 1'b0);
    pulse_dirty();
    track = 6'd6;
    serve_track(1'b0, 78, SPT, 1'b0);
  endtask

  task automatic test_mount_abort();
    img_readonly = 1'b0;
    track = 6'd3;
    serve_track(1'b0, 39, 4, 1'b1);
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'd43 || track_sec !== 4'd4) begin
      errors++;
      $display("FAIL blk4_req: rd=%b lba=%0d sec=%0d, required 1 43 4", sd_rd, sd_lba, track_sec);
    end
    pulse_dirty();
    pulse_mount(1'b0);
    checks++;
    if (sd_rd !== 1'b0 || busy !== 1'b0 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL abort: rd=%b busy=%b wait=%b, required 0 0 0", sd_rd, busy, cpu_wait);
    end
    serve_track(1'b0, 39, SPT, 1'b0);
    track = 6'd4;
    serve_track(1'b0, 52, SPT, 1'b0);
  endtask

  task automatic test_reset_flush();
    pulse_dirty();
    track = 6'd7;
    repeat (2) @(negedge clk_sys);
    checks++;
    if (sd_wr !== 1'b1 || sd_lba !== 32'd52) begin
      errors++;
      $display("FAIL flush_req: wr=%b lba=%0d, required 1 52", sd_wr, sd_lba);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({sd_rd, sd_wr, cpu_wait, busy} !== 4'b0 || track_sec !== 4'd0 || sd_lba !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: rd=%b wr=%b wait=%b busy=%b sec=%0d lba=%0d, required all 0",
               sd_rd, sd_wr, cpu_wait, busy, track_sec, sd_lba);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    serve_track(1'b0, 91, SPT, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mount_load();
    test_stray_ack();
    test_clean_seek();
    test_back_to_back();
    test_readonly();
    test_mount_abort();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
